// File: rtl/common.sv
// Shared bus types for the instruction- and data-side bus bridges.
package common;

  localparam int unsigned WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  // Request bundle driven by a bus master
  typedef struct packed {
    logic  valid;
    word_t addr;
  } ibus_req_t;

  // Response bundle returned by the bus slave
  typedef struct packed {
    logic  addr_ok;
    logic  data_ok;
    word_t data;
  } ibus_resp_t;

endpackage

// File: rtl/fetch_pkg.sv
// Fetch-stage types and helpers.
package fetch_pkg;

  import common::*;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_ADDR = 3'd1,
    WAIT_DATA = 3'd2,
    HOLD      = 3'd3,
    DROP_ADDR = 3'd4,
    DROP_DATA = 3'd5
  } ifetch_state_t;

  // Instruction fetches must be word aligned
  function automatic logic misaligned(word_t addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/ifetch_unit_if.sv
// SRAM-like instruction bus: request/addr_ok/data_ok handshake.
interface ifetch_unit_if;

  import common::*;

  logic  ireq_valid;
  word_t ireq_addr;
  logic  ireq_addr_ok;
  logic  iresp_data_ok;
  word_t iresp_data;

  modport master (
    output ireq_valid,
    output ireq_addr,
    input  ireq_addr_ok,
    input  iresp_data_ok,
    input  iresp_data
  );

  modport slave (
    input  ireq_valid,
    input  ireq_addr,
    output ireq_addr_ok,
    output iresp_data_ok,
    output iresp_data
  );

endinterface

// File: rtl/ifetch_unit.sv
// Instruction-fetch bus controller: one request per PC, holds the word across
// fetch stalls and silently drains responses made stale by a redirect.
module ifetch_unit
  import common::*;
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         resetn,
  input  word_t        pc,
  input  logic         stallF,
  input  logic         redirect,
  ifetch_unit_if.master ibus,
  output logic         i_data_ok,
  output word_t        instr,
  output word_t        fetch_pc,
  output logic         adel
);

  ifetch_state_t state_q, state_d;
  word_t         req_pc_q, req_pc_d;
  word_t         hold_instr_q, hold_instr_d;

  ibus_req_t     req_c;
  ibus_resp_t    resp_c;
  logic          ok_c;
  word_t         instr_c;
  word_t         fetch_pc_c;
  logic          adel_c;

  assign resp_c.addr_ok = ibus.ireq_addr_ok;
  assign resp_c.data_ok = ibus.iresp_data_ok;
  assign resp_c.data    = ibus.iresp_data;

  // State and captured request/instruction registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      req_pc_q     <= '0;
      hold_instr_q <= '0;
    end else begin
      state_q      <= state_d;
      req_pc_q     <= req_pc_d;
      hold_instr_q <= hold_instr_d;
    end
  end

  // Next-state and combinational bus/fetch outputs
  always_comb begin
    state_d      = state_q;
    req_pc_d     = req_pc_q;
    hold_instr_d = hold_instr_q;
    req_c        = '0;
    ok_c         = 1'b0;
    instr_c      = '0;
    fetch_pc_c   = req_pc_q;
    adel_c       = 1'b0;

    case (state_q)
      IDLE: begin
        if (misaligned(pc)) begin
          // Misaligned PC never reaches the bus; flag it to the pipeline
          ok_c       = 1'b1;
          fetch_pc_c = pc;
          adel_c     = 1'b1;
        end else if (!redirect) begin
          req_c.valid = 1'b1;
          req_c.addr  = pc;
          req_pc_d    = pc;
          state_d     = resp_c.addr_ok ? WAIT_DATA : WAIT_ADDR;
        end
      end

      WAIT_ADDR: begin
        req_c.valid = 1'b1;
        req_c.addr  = req_pc_q;
        if (redirect) begin
          state_d = resp_c.addr_ok ? DROP_DATA : DROP_ADDR;
        end else if (resp_c.addr_ok) begin
          state_d = WAIT_DATA;
        end
      end

      WAIT_DATA: begin
        if (resp_c.data_ok) begin
          if (redirect) begin
            state_d = IDLE;
          end else begin
            ok_c       = 1'b1;
            instr_c    = resp_c.data;
            fetch_pc_c = req_pc_q;
            if (stallF) begin
              hold_instr_d = resp_c.data;
              state_d      = HOLD;
            end else begin
              state_d = IDLE;
            end
          end
        end else if (redirect) begin
          state_d = DROP_DATA;
        end
      end

      HOLD: begin
        ok_c       = 1'b1;
        instr_c    = hold_instr_q;
        fetch_pc_c = req_pc_q;
        if (!stallF || redirect) begin
          state_d = IDLE;
        end
      end

      DROP_ADDR: begin
        // A request already on the bus cannot be withdrawn; finish it quietly
        req_c.valid = 1'b1;
        req_c.addr  = req_pc_q;
        if (resp_c.addr_ok) begin
          state_d = DROP_DATA;
        end
      end

      DROP_DATA: begin
        if (resp_c.data_ok) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs are forced low while the core and bus are held in reset
  assign ibus.ireq_valid = resetn & req_c.valid;
  assign ibus.ireq_addr  = resetn ? req_c.addr : '0;
  assign i_data_ok       = resetn & ok_c;
  assign instr           = resetn ? instr_c : '0;
  assign fetch_pc        = resetn ? fetch_pc_c : '0;
  assign adel            = resetn & adel_c;

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: directed vector table, reset sequence,
// and randomized traffic against a transaction-level fetch model.
module tb_ifetch_unit;

  import common::*;

  localparam word_t P0 = 32'hbfc00000;
  localparam word_t P1 = 32'hbfc00004;
  localparam word_t P2 = 32'hbfc00008;
  localparam word_t PX = 32'hbfc00380;
  localparam word_t PM = 32'hbfc00002;
  localparam word_t I0 = 32'h24080001;
  localparam word_t I1 = 32'h3c1d0001;
  localparam word_t G  = 32'hdeadbeef;

  logic  clk;
  logic  resetn;
  word_t pc;
  logic  stallF;
  logic  redirect;
  logic  i_data_ok;
  word_t instr;
  word_t fetch_pc;
  logic  adel;

  int n_tests;
  int n_fail;

  ifetch_unit_if ibus ();

  ifetch_unit dut (
    .clk       (clk),
    .resetn    (resetn),
    .pc        (pc),
    .stallF    (stallF),
    .redirect  (redirect),
    .ibus      (ibus),
    .i_data_ok (i_data_ok),
    .instr     (instr),
    .fetch_pc  (fetch_pc),
    .adel      (adel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic  stall;
    logic  redir;
    word_t pc;
    logic  ao;
    logic  dok;
    word_t data;
    logic  e_valid;
    word_t e_addr;
    logic  e_ok;
    word_t e_instr;
    word_t e_fpc;
    logic  e_adel;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic st, input logic rd, input word_t p, input logic ao,
                     input logic dk, input word_t d, input logic ev, input word_t ea,
                     input logic eo, input word_t ei, input word_t ef, input logic ead);
    vec_t v;
    v.stall = st; v.redir = rd; v.pc = p; v.ao = ao; v.dok = dk; v.data = d;
    v.e_valid = ev; v.e_addr = ea; v.e_ok = eo; v.e_instr = ei; v.e_fpc = ef; v.e_adel = ead;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic st, input logic rd, input word_t p, input logic ao,
                       input logic dk, input word_t d);
    stallF             = st;
    redirect           = rd;
    pc                 = p;
    ibus.ireq_addr_ok  = ao;
    ibus.iresp_data_ok = dk;
    ibus.iresp_data    = d;
  endtask

  // strict: compare every field even when it would otherwise be don't-care
  task automatic check(input string name, input logic strict, input logic ev, input word_t ea,
                       input logic eo, input word_t ei, input word_t ef, input logic ead);
    logic bad;
    bad = (ibus.ireq_valid !== ev) || (i_data_ok !== eo) || (adel !== ead);
    if (ev || strict) bad = bad || (ibus.ireq_addr !== ea);
    if (eo || strict) bad = bad || (instr !== ei) || (fetch_pc !== ef);
    n_tests++;
    if (bad) begin
      n_fail++;
      $display("FAIL %s: got valid=%b addr=%h ok=%b instr=%h pc=%h adel=%b; want valid=%b addr=%h ok=%b instr=%h pc=%h adel=%b",
               name, ibus.ireq_valid, ibus.ireq_addr, i_data_ok, instr, fetch_pc, adel,
               ev, ea, eo, ei, ef, ead);
    end
  endtask

  // Transaction-level model state
  bit    m_busy, m_acc, m_stale, m_have;
  word_t m_rpc, m_hword;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    resetn  = 1'b0;
    drive(1'b0, 1'b0, PM, 1'b1, 1'b0, G);

    // Reset: outputs forced low even with a misaligned PC at the input
    @(negedge clk);
    #1 check("reset_misaligned", 1'b1, 1'b0, '0, 1'b0, '0, '0, 1'b0);
    @(negedge clk);
    drive(1'b0, 1'b0, P0, 1'b1, 1'b0, G);
    #1 check("reset_aligned", 1'b1, 1'b0, '0, 1'b0, '0, '0, 1'b0);
    @(negedge clk);
    resetn = 1'b1;
    drive(1'b0, 1'b1, P0, 1'b0, 1'b0, G);

    // Zero-wait fetch with stall across data_ok, then release
    add(0,0,P0,1,0,G,  1,P0, 0,0,0,0);
    add(1,0,P0,0,1,I0, 0,0,  1,I0,P0,0);
    add(1,0,P0,0,0,G,  0,0,  1,I0,P0,0);
    add(1,0,P0,0,0,G,  0,0,  1,I0,P0,0);
    add(0,0,P0,0,0,G,  0,0,  1,I0,P0,0);
    add(0,0,P1,1,0,G,  1,P1, 0,0,0,0);
    add(0,0,P1,0,1,I1, 0,0,  1,I1,P1,0);
    add(0,0,P2,1,0,G,  1,P2, 0,0,0,0);
    // Redirect in WAIT_DATA, stale data_ok four cycles later
    add(0,1,PX,0,0,G,  0,0,  0,0,0,0);
    add(0,0,PX,0,0,G,  0,0,  0,0,0,0);
    add(0,0,PX,0,0,G,  0,0,  0,0,0,0);
    add(0,0,PX,0,0,G,  0,0,  0,0,0,0);
    add(0,0,PX,0,1,I1, 0,0,  0,0,0,0);
    // addr_ok withheld, redirect in second cycle
    add(0,0,PX,0,0,G,  1,PX, 0,0,0,0);
    add(0,1,P0,0,0,G,  1,PX, 0,0,0,0);
    add(0,0,P0,0,0,G,  1,PX, 0,0,0,0);
    add(0,0,P0,1,0,G,  1,PX, 0,0,0,0);
    add(0,0,P0,0,1,I0, 0,0,  0,0,0,0);
    // Misaligned PC, redirect irrelevant
    add(0,0,PM,0,0,G,  0,0,  1,0,PM,1);
    add(0,1,PM,0,0,G,  0,0,  1,0,PM,1);
    // Aligned PC with redirect: request suppressed
    add(0,1,P0,1,0,G,  0,0,  0,0,0,0);
    // Stall and redirect together in HOLD
    add(0,0,P0,1,0,G,  1,P0, 0,0,0,0);
    add(1,0,P0,0,1,I0, 0,0,  1,I0,P0,0);
    add(1,1,P0,0,0,G,  0,0,  1,I0,P0,0);
    // data_ok with redirect in WAIT_DATA
    add(0,0,P1,1,0,G,  1,P1, 0,0,0,0);
    add(0,1,P1,0,1,I1, 0,0,  0,0,0,0);
    // addr_ok with redirect in WAIT_ADDR, redirect ignored while draining
    add(0,0,P0,0,0,G,  1,P0, 0,0,0,0);
    add(0,1,P0,1,0,G,  1,P0, 0,0,0,0);
    add(0,1,P0,0,0,G,  0,0,  0,0,0,0);
    add(0,0,P0,0,1,I0, 0,0,  0,0,0,0);
    // One wait state on address
    add(0,0,P1,0,0,G,  1,P1, 0,0,0,0);
    add(0,0,P1,1,0,G,  1,P1, 0,0,0,0);
    add(0,0,P1,0,1,I1, 0,0,  1,I1,P1,0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].stall, vecs[i].redir, vecs[i].pc, vecs[i].ao, vecs[i].dok, vecs[i].data);
      #1 check($sformatf("vec%0d", i), 1'b0, vecs[i].e_valid, vecs[i].e_addr, vecs[i].e_ok,
               vecs[i].e_instr, vecs[i].e_fpc, vecs[i].e_adel);
    end

    // Reset asserted while in WAIT_DATA
    @(negedge clk);
    drive(0, 0, P0, 1, 0, G);
    #1 check("rst_seq_issue", 1'b0, 1'b1, P0, 1'b0, '0, '0, 1'b0);
    @(negedge clk);
    resetn = 1'b0;
    drive(0, 0, P1, 0, 0, G);
    #1 check("rst_seq_assert", 1'b1, 1'b0, '0, 1'b0, '0, '0, 1'b0);
    @(negedge clk);
    #1 check("rst_seq_held", 1'b1, 1'b0, '0, 1'b0, '0, '0, 1'b0);
    @(negedge clk);
    resetn = 1'b1;
    drive(0, 0, P1, 1, 0, G);
    #1 check("rst_seq_first_req", 1'b0, 1'b1, P1, 1'b0, '0, '0, 1'b0);
    @(negedge clk);
    drive(0, 0, P1, 0, 1, I1);
    #1 check("rst_seq_first_data", 1'b0, 1'b0, '0, 1'b1, I1, P1, 1'b0);

    // Randomized traffic against the transaction model
    @(negedge clk);
    resetn = 1'b0;
    drive(0, 0, P0, 0, 0, G);
    m_busy = 0; m_acc = 0; m_stale = 0; m_have = 0; m_rpc = '0; m_hword = '0;
    @(negedge clk);
    resetn = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      logic  st, rd, ao, dk;
      word_t p, d;
      logic  ev, eo, ead;
      word_t ea, ei, ef;
      bit    n_busy, n_acc, n_stale, n_have;
      word_t n_rpc, n_hword;
      if (c > 0) @(negedge clk);
      st = ($urandom_range(0, 2) == 0);
      rd = ($urandom_range(0, 5) == 0);
      ao = $urandom_range(0, 1) != 0;
      dk = m_busy && m_acc && ($urandom_range(0, 2) != 0);
      p  = 32'hbfc00000 + 32'($urandom_range(0, 63) * 4);
      if ($urandom_range(0, 11) == 0) p = p + 32'($urandom_range(1, 3));
      d  = 32'($urandom);
      drive(st, rd, p, ao, dk, d);
      #1;
      ev = 0; ea = '0; eo = 0; ei = '0; ef = '0; ead = 0;
      n_busy = m_busy; n_acc = m_acc; n_stale = m_stale; n_have = m_have;
      n_rpc = m_rpc; n_hword = m_hword;
      if (m_have) begin
        eo = 1; ei = m_hword; ef = m_rpc;
        if (!st || rd) n_have = 0;
      end else if (!m_busy) begin
        if (p[1:0] != 2'b00) begin
          eo = 1; ef = p; ead = 1;
        end else if (!rd) begin
          ev = 1; ea = p;
          n_busy = 1; n_rpc = p; n_acc = ao; n_stale = 0;
        end
      end else if (!m_acc) begin
        ev = 1; ea = m_rpc;
        if (rd) n_stale = 1;
        if (ao) n_acc = 1;
      end else if (dk) begin
        n_busy = 0;
        if (!m_stale && !rd) begin
          eo = 1; ei = d; ef = m_rpc;
          if (st) begin
            n_have = 1; n_hword = d;
          end
        end
      end else if (rd) begin
        n_stale = 1;
      end
      check($sformatf("rand%0d", c), 1'b0, ev, ea, eo, ei, ef, ead);
      m_busy = n_busy; m_acc = n_acc; m_stale = n_stale; m_have = n_have;
      m_rpc = n_rpc; m_hword = n_hword;
    end

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
